// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction over a
// req/ready handshake, and drives the IF/ID register with instructions or NOP bubbles.
module if_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [15:0] pc_plus1,
  output logic        instr_valid
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_plus1_q, pc_plus1_d;
  logic        vld_q, vld_d;
  logic [15:0] hold_buf_q, hold_buf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_plus1_q <= 16'h0000;
      vld_q      <= 1'b0;
      hold_buf_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      vld_q      <= vld_d;
      hold_buf_q <= hold_buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    vld_d      = vld_q;
    hold_buf_d = hold_buf_q;

    // A redirect overrides everything, including a word returned this cycle.
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      instr_d    = NOP_INSTR;
      vld_d      = 1'b0;
      hold_buf_d = 16'h0000;
      state_d    = FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready && !stall) begin
            instr_d    = imem_rdata;
            pc_plus1_d = pc_q + 16'd1;
            vld_d      = 1'b1;
            pc_d       = pc_q + 16'd1;
          end else if (imem_ready && stall) begin
            // Word arrived while decode is blocked: park it rather than refetch.
            hold_buf_d = imem_rdata;
            pc_d       = pc_q + 16'd1;
            state_d    = HOLD;
          end else if (!imem_ready && !stall) begin
            instr_d = NOP_INSTR;
            vld_d   = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            // pc already advanced past the buffered word, so pc itself is its +1.
            instr_d    = hold_buf_q;
            pc_plus1_d = pc_q;
            vld_d      = 1'b1;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign imem_req    = (state_q == FETCH) && !rst;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign pc_plus1    = pc_plus1_q;
  assign instr_valid = vld_q;

endmodule
